// File: rtl/acc_cpu_param.sv
// rtl/acc_cpu_param.sv - parametrised multi-cycle accumulator CPU (T0-T4 cycle, host load, debug read)

module acc_cpu_param #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [DW-1:0] load_data,
   input  logic          start,
   input  logic [AW-1:0] start_pc,
   input  logic [AW-1:0] dbg_addr,
   output logic [DW-1:0] dbg_data,
   output logic [DW-1:0] ac_out,
   output logic [AW-1:0] pc_out,
   output logic          busy,
   output logic          halted,
   output logic          z_flag,
   output logic          c_flag
);

   localparam int DEPTH = 1 << AW;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_T0   = 3'd1;
   localparam logic [2:0] S_T1   = 3'd2;
   localparam logic [2:0] S_T2   = 3'd3;
   localparam logic [2:0] S_T3   = 3'd4;
   localparam logic [2:0] S_T4   = 3'd5;
   localparam logic [2:0] S_HALT = 3'd6;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_DBL = 3'b011;
   localparam logic [2:0] OP_LDA = 3'b100;
   localparam logic [2:0] OP_STA = 3'b101;
   localparam logic [2:0] OP_CMM = 3'b110;
   localparam logic [2:0] OP_HLT = 3'b111;

   logic [2:0]    state_q, state_d;
   logic [DW-1:0] ac_q, ac_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [AW-1:0] ar_q, ar_d;
   logic [AW+3:0] ir_q, ir_d;
   logic          z_q, z_d;
   logic          c_q, c_d;

   logic [DW-1:0] mem_q [DEPTH];
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_wdata;

   logic          ir_ind;
   logic [2:0]    ir_op;
   logic [AW-1:0] ir_addr;
   logic [DW-1:0] m_ar;
   logic [DW:0]   sum;
   logic [DW:0]   diff;

   assign ir_ind  = ir_q[AW+3];
   assign ir_op   = ir_q[AW+2:AW];
   assign ir_addr = ir_q[AW-1:0];
   assign m_ar    = mem_q[ar_q];
   // Extra top bit carries the ADD carry-out and the SUB borrow (AC < M unsigned).
   assign sum     = {1'b0, ac_q} + {1'b0, m_ar};
   assign diff    = {1'b0, ac_q} - {1'b0, m_ar};

   // Next-state, datapath and memory-write decode for the instruction cycle.
   always_comb begin
      state_d   = state_q;
      ac_d      = ac_q;
      pc_d      = pc_q;
      ar_d      = ar_q;
      ir_d      = ir_q;
      z_d       = z_q;
      c_d       = c_q;
      mem_we    = 1'b0;
      mem_waddr = ar_q;
      mem_wdata = ac_q;
      case (state_q)
         S_IDLE, S_HALT: begin
            // Host writes are only accepted while stopped; a same-cycle start
            // fetches after this edge, so the first fetch sees the new data.
            if (load_en) begin
               mem_we    = 1'b1;
               mem_waddr = load_addr;
               mem_wdata = load_data;
            end
            if (start) begin
               pc_d    = start_pc;
               state_d = S_T0;
            end
         end
         S_T0: begin
            ar_d    = pc_q;
            state_d = S_T1;
         end
         S_T1: begin
            ir_d    = m_ar[AW+3:0];
            pc_d    = pc_q + {{(AW-1){1'b0}}, 1'b1};
            state_d = S_T2;
         end
         S_T2: begin
            ar_d    = ir_addr;
            state_d = S_T3;
         end
         S_T3: begin
            // Direct instructions idle here so both modes take five cycles.
            if (ir_ind) begin
               ar_d = m_ar[AW-1:0];
            end
            state_d = S_T4;
         end
         S_T4: begin
            state_d = S_T0;
            case (ir_op)
               OP_ADD: begin
                  ac_d = sum[DW-1:0];
                  c_d  = sum[DW];
                  z_d  = (sum[DW-1:0] == '0);
               end
               OP_SUB: begin
                  ac_d = diff[DW-1:0];
                  c_d  = diff[DW];
                  z_d  = (diff[DW-1:0] == '0);
               end
               OP_XOR: begin
                  ac_d = ac_q ^ m_ar;
                  z_d  = ((ac_q ^ m_ar) == '0);
               end
               OP_DBL: begin
                  mem_we    = 1'b1;
                  mem_wdata = {m_ar[DW-2:0], 1'b0};
                  c_d       = m_ar[DW-1];
               end
               OP_LDA: begin
                  ac_d = m_ar;
                  z_d  = (m_ar == '0);
               end
               OP_STA: begin
                  mem_we    = 1'b1;
                  mem_wdata = ac_q;
               end
               OP_CMM: begin
                  mem_we    = 1'b1;
                  mem_wdata = ~m_ar;
               end
               OP_HLT: begin
                  state_d = S_HALT;
               end
               default: begin
                  state_d = S_T0;
               end
            endcase
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Architectural registers; reset aborts any instruction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ac_q    <= '0;
         pc_q    <= '0;
         ar_q    <= '0;
         ir_q    <= '0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         ac_q    <= ac_d;
         pc_q    <= pc_d;
         ar_q    <= ar_d;
         ir_q    <= ir_d;
         z_q     <= z_d;
         c_q     <= c_d;
      end
   end

   // Memory array keeps its contents across reset; the write enable is
   // state-derived, so an asserted reset suppresses any pending write.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign dbg_data = mem_q[dbg_addr];
   assign ac_out   = ac_q;
   assign pc_out   = pc_q;
   assign busy     = (state_q == S_T0) || (state_q == S_T1) || (state_q == S_T2) ||
                     (state_q == S_T3) || (state_q == S_T4);
   assign halted   = (state_q == S_HALT);
   assign z_flag   = z_q;
   assign c_flag   = c_q;

endmodule

// File: tb/tb_acc_cpu_param.sv
// tb/tb_acc_cpu_param.sv - scoreboard bench for acc_cpu_param

module tb_acc_cpu_param;

   logic       clk;
   logic       rst_n;
   logic       load_en;
   logic [3:0] load_addr;
   logic [7:0] load_data;
   logic       start;
   logic [3:0] start_pc;
   logic [3:0] dbg_addr;
   logic [7:0] dbg_data;
   logic [7:0] ac_out;
   logic [3:0] pc_out;
   logic       busy;
   logic       halted;
   logic       z_flag;
   logic       c_flag;

   typedef struct packed {
      logic [7:0]  ac;
      logic [3:0]  pc;
      logic        z;
      logic        c;
      logic [15:0] cyc;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   acc_cpu_param #(.DW(8), .AW(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_en   (load_en),
      .load_addr (load_addr),
      .load_data (load_data),
      .start     (start),
      .start_pc  (start_pc),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data),
      .ac_out    (ac_out),
      .pc_out    (pc_out),
      .busy      (busy),
      .halted    (halted),
      .z_flag    (z_flag),
      .c_flag    (c_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      @(negedge clk);
      load_en   = 1'b0;
   endtask

   task automatic dbg_check(input string tag, input logic [3:0] a, input logic [7:0] exp);
      dbg_addr = a;
      #1;
      check(tag, {24'd0, dbg_data}, {24'd0, exp});
   endtask

   // mode 0: plain run; 1: host write while in T2; 2: start held during busy
   task automatic run_prog(input string tag, input logic [3:0] spc, input int mode, input exp_t e);
      int   cnt;
      exp_t got;
      sb.push_back(e);
      @(negedge clk);
      start    = 1'b1;
      start_pc = spc;
      @(posedge clk);
      #1;
      start = 1'b0;
      cnt   = 0;
      while (cnt < 200) begin
         @(posedge clk);
         #1;
         cnt++;
         if (mode == 1 && cnt == 2) begin
            load_en   = 1'b1;
            load_addr = 4'd15;
            load_data = 8'h99;
         end
         if (mode == 1 && cnt == 3) load_en = 1'b0;
         if (mode == 2 && cnt == 1) begin
            start    = 1'b1;
            start_pc = 4'd5;
         end
         if (mode == 2 && cnt == 8) start = 1'b0;
         if (halted) break;
      end
      got = sb.pop_front();
      check({tag, "_halted"}, {31'd0, halted}, 32'd1);
      check({tag, "_busy"},   {31'd0, busy},   32'd0);
      check({tag, "_cycles"}, cnt,             {16'd0, got.cyc});
      check({tag, "_ac"},     {24'd0, ac_out}, {24'd0, got.ac});
      check({tag, "_pc"},     {28'd0, pc_out}, {28'd0, got.pc});
      check({tag, "_z"},      {31'd0, z_flag}, {31'd0, got.z});
      check({tag, "_c"},      {31'd0, c_flag}, {31'd0, got.c});
   endtask

   initial begin
      rst_n     = 1'b0;
      load_en   = 1'b0;
      load_addr = '0;
      load_data = '0;
      start     = 1'b0;
      start_pc  = '0;
      dbg_addr  = '0;
      #1;
      check("rst_ac",     {24'd0, ac_out}, 32'd0);
      check("rst_pc",     {28'd0, pc_out}, 32'd0);
      check("rst_busy",   {31'd0, busy},   32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
      check("rst_z",      {31'd0, z_flag}, 32'd0);
      check("rst_c",      {31'd0, c_flag}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // basic program: LDA 8, ADD 9, STA 10, HLT
      load(4'd0, 8'h48); load(4'd1, 8'h09); load(4'd2, 8'h5A); load(4'd3, 8'h70);
      load(4'd8, 8'h05); load(4'd9, 8'h03);
      run_prog("basic", 4'd0, 0, '{ac: 8'h08, pc: 4'd4, z: 1'b0, c: 1'b0, cyc: 16'd20});
      dbg_check("basic_m10", 4'd10, 8'h08);

      // indirect LDA through M5 -> M11
      load(4'd0, 8'hC5); load(4'd5, 8'h0B); load(4'd11, 8'h77); load(4'd1, 8'h70);
      run_prog("indirect", 4'd0, 0, '{ac: 8'h77, pc: 4'd2, z: 1'b0, c: 1'b0, cyc: 16'd10});

      // flags: LDA 3, SUB 5 -> FE with borrow; then XOR FE -> 0
      load(4'd0, 8'h4C); load(4'd1, 8'h1D); load(4'd2, 8'h70);
      load(4'd12, 8'h03); load(4'd13, 8'h05);
      run_prog("sub", 4'd0, 0, '{ac: 8'hFE, pc: 4'd3, z: 1'b0, c: 1'b1, cyc: 16'd15});
      load(4'd0, 8'h2E); load(4'd1, 8'h70); load(4'd14, 8'hFE);
      run_prog("xor", 4'd0, 0, '{ac: 8'h00, pc: 4'd2, z: 1'b1, c: 1'b1, cyc: 16'd10});

      // memory ops: DBL with MSB clear, DBL with MSB set, CMM
      load(4'd7, 8'h21); load(4'd0, 8'h37); load(4'd1, 8'h70);
      run_prog("dbl0", 4'd0, 0, '{ac: 8'h00, pc: 4'd2, z: 1'b1, c: 1'b0, cyc: 16'd10});
      dbg_check("dbl0_m7", 4'd7, 8'h42);
      load(4'd6, 8'h81); load(4'd0, 8'h36);
      run_prog("dbl1", 4'd0, 0, '{ac: 8'h00, pc: 4'd2, z: 1'b1, c: 1'b1, cyc: 16'd10});
      dbg_check("dbl1_m6", 4'd6, 8'h02);
      load(4'd0, 8'h66);
      run_prog("cmm", 4'd0, 0, '{ac: 8'h00, pc: 4'd2, z: 1'b1, c: 1'b1, cyc: 16'd10});
      dbg_check("cmm_m6", 4'd6, 8'hFD);

      // host write during T2 ignored; start during busy ignored
      load(4'd0, 8'h4F); load(4'd1, 8'h70); load(4'd15, 8'h11);
      run_prog("ld_busy", 4'd0, 1, '{ac: 8'h11, pc: 4'd2, z: 1'b0, c: 1'b1, cyc: 16'd10});
      dbg_check("ld_busy_m15", 4'd15, 8'h11);
      run_prog("st_busy", 4'd0, 2, '{ac: 8'h11, pc: 4'd2, z: 1'b0, c: 1'b1, cyc: 16'd10});

      // PC wrap: LDA 13 at address 15, HLT at address 0
      load(4'd15, 8'h4D); load(4'd0, 8'h70); load(4'd13, 8'h5C);
      run_prog("wrap", 4'd15, 0, '{ac: 8'h5C, pc: 4'd1, z: 1'b0, c: 1'b1, cyc: 16'd10});

      // asynchronous reset during T4 of STA 11
      load(4'd0, 8'h5B); load(4'd1, 8'h70);
      @(negedge clk);
      start    = 1'b1;
      start_pc = 4'd0;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("t4_busy", {31'd0, busy}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_busy",   {31'd0, busy},   32'd0);
      check("ar_halted", {31'd0, halted}, 32'd0);
      check("ar_ac",     {24'd0, ac_out}, 32'd0);
      check("ar_pc",     {28'd0, pc_out}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      dbg_check("ar_m11", 4'd11, 8'h77);
      check("ar_z", {31'd0, z_flag}, 32'd0);
      check("ar_c", {31'd0, c_flag}, 32'd0);
      check("ar_idle", {31'd0, busy | halted}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/acc_cpu_param.md
Name: acc_cpu_param

Overview:
Parametrised multi-cycle accumulator CPU with a fixed 5-state instruction cycle (T0–T4).
Adds a host program-load port, start/halt control, a HLT opcode, carry/zero flags, configurable data and address widths, and a debug memory read port.
Sits as the core under the team's test benches, which preload memory, start execution and check results.

Parameters:
DW, 8, data/memory word width; must be >= AW+4
AW, 4, address width; memory depth 2**AW

Ports:
clk  in  1  clock; all state changes on posedge
rst_n  in  1  asynchronous active-low reset
load_en  in  1  host write strobe into memory
load_addr  in  AW  host write address
load_data  in  DW  host write data
start  in  1  begin execution
start_pc  in  AW  first fetch address, taken with start
dbg_addr  in  AW  debug read address
dbg_data  out  DW  combinational M[dbg_addr]
ac_out  out  DW  accumulator
pc_out  out  AW  program counter
busy  out  1  high in T0–T4
halted  out  1  high in HALT state
z_flag  out  1  zero flag
c_flag  out  1  carry/borrow flag

Behaviour:
- Instruction word format (low AW+4 bits; upper bits ignored):
  - bit AW+3 = I (indirect)
  - bits AW+2:AW = opcode
  - bits AW-1:0 = address
- States: IDLE, T0, T1, T2, T3, T4, HALT.
- Reset, asynchronous:
  - state=IDLE, AC=0, PC=0, AR=0, IR=0, z=0, c=0, busy=0, halted=0.
  - Memory contents are not reset.
  - Reset mid-instruction aborts it; no memory write occurs.
- IDLE/HALT + start=1: PC<=start_pc, flags unchanged, next state T0.
- T0: AR<=PC.
- T1: IR<=M[AR]; PC<=PC+1, modulo 2**AW (15 wraps to 0).
- T2: AR<=IR address field.
- T3: if I=1, AR<=M[AR][AW-1:0]; otherwise no-op. Cycle count is the same for direct and indirect.
- T4 execute, then T0 (or HALT for HLT):
  - 000 ADD: {c,AC}<=AC+M[AR]; z<=(AC==0)
  - 001 SUB: AC<=AC-M[AR]; c<=borrow (AC<M unsigned); z updated
  - 010 XOR: AC<=AC^M[AR]; z updated; c unchanged
  - 011 DBL: M[AR]<=M[AR]<<1; c<=old MSB; z unchanged
  - 100 LDA: AC<=M[AR]; z updated; c unchanged
  - 101 STA: M[AR]<=AC; flags unchanged
  - 110 CMM: M[AR]<=~M[AR]; flags unchanged
  - 111 HLT: next state HALT; PC stays pointing past the HLT
- Each instruction takes exactly 5 cycles. Execution is continuous until HLT.
- start while busy is ignored.
- load_en:
  - Writes M[load_addr]<=load_data only when not busy; ignored in T0–T4.
  - load_en and start in the same cycle: the write occurs and start is taken. The first fetch sees the new data.
- Debug port: dbg_data is purely combinational, so a same-cycle write shows only after the clock edge.
- busy=1 exactly in T0–T4; halted=1 only in HALT; both 0 in IDLE.
- Subsequent start from HALT resumes at start_pc.

Test Plan:
1. Basic program:
   - Stimulus: load M0=0x48, M1=0x09, M2=0x5A, M3=0x70, M8=0x05, M9=0x03; start_pc=0; start.
   - Response: halted rises 20 cycles after start; AC=0x08, M10=0x08 via dbg; pc_out=4; z=0, c=0.
2. Indirect LDA:
   - Stimulus: M0=0xC5, M5=0x0B, M11=0x77, M1=0x70; start.
   - Response: AC=0x77 at halt; instruction takes 5 cycles, same as direct.
3. Flags:
   - Stimulus: LDA 0x03, SUB 0x05, then XOR with 0xFE.
   - Response: after SUB, AC=0xFE, c=1, z=0; after XOR, AC=0x00, z=1, c still 1.
4. Memory ops:
   - Stimulus: M6=0x81; run 0x36 (DBL 6), then 0x66 (CMM 6).
   - Response: after DBL, M6=0x02, c=1; after CMM, M6=0xFD.
5. Control corner cases:
   - load_en during T2 → memory unchanged.
   - start during busy → ignored.
   - Program with no HLT running at PC=15 → next fetch from 0.
6. Reset mid-instruction:
   - Stimulus: assert rst_n low during T4 of an STA.
   - Response: target word unchanged; AC=0, PC=0, IDLE, busy=0 immediately (asynchronous).
